// File: rtl/mvm_axis_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mvm_axis_loader
// Purpose  : Turns per-job commands plus a data-beat stream into mvm_top
//            AXIS flits, generating RF address, op code, lane select and dest.
// Revision : 1.0 - initial release
// ============================================================================
module mvm_axis_loader #(
  parameter int DATAW = 512,
  parameter int DESTW = 12,
  parameter int IDW   = 12,
  parameter int USERW = 75,
  parameter int LANES = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [DESTW-1:0] CMD_DEST,
  input  logic [7:0]       CMD_COUNT,
  input  logic [8:0]       CMD_RF_ADDR,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic [DATAW-1:0] DIN_DATA,
  output logic             AXIS_M_TVALID,
  input  logic             AXIS_M_TREADY,
  output logic [DATAW-1:0] AXIS_M_TDATA,
  output logic             AXIS_M_TLAST,
  output logic [IDW-1:0]   AXIS_M_TID,
  output logic [USERW-1:0] AXIS_M_TUSER,
  output logic [DESTW-1:0] AXIS_M_TDEST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int       LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [1:0] OP_WEIGHT = 2'b11;
  localparam logic [1:0] OP_RSVD   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_done_nxt;

  logic [1:0]       r_op;
  logic [DESTW-1:0] r_dest;
  logic [7:0]       r_count;
  logic [8:0]       r_rf_addr;
  logic [LW-1:0]    r_l;
  logic [7:0]       r_r;
  logic             r_done;

  logic             r_tvalid;
  logic [DATAW-1:0] r_tdata;
  logic             r_tlast;
  logic [USERW-1:0] r_tuser;
  logic [DESTW-1:0] r_tdest;

  logic             w_cmd_fire;
  logic             w_cmd_null;
  logic             w_din_fire;
  logic             w_out_fire;
  logic             w_lane_last;
  logic             w_last_beat;
  logic [LANES-1:0] w_lane_sel;
  logic [8:0]       w_rf;

  assign w_cmd_fire  = (r_state == S_IDLE) && CMD_VALID;
  assign w_cmd_null  = (CMD_COUNT == 8'd0) || (CMD_OP == OP_RSVD);
  assign w_out_fire  = r_tvalid && AXIS_M_TREADY;
  assign w_din_fire  = (r_state == S_SEND) && DIN_VALID && (!r_tvalid || AXIS_M_TREADY);
  assign w_lane_last = (r_l == LW'(LANES - 1));
  assign w_last_beat = (r_op == OP_WEIGHT) ? (w_lane_last && (r_r == r_count - 8'd1))
                                           : (r_r == r_count - 8'd1);
  assign w_lane_sel  = (r_op == OP_WEIGHT) ? (LANES'(1) << r_l) : '0;
  assign w_rf        = (r_op == OP_WEIGHT) ? r_rf_addr : 9'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    CMD_READY   = 1'b0;
    DIN_READY   = 1'b0;
    BUSY        = 1'b0;
    case (r_state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          if (w_cmd_null) w_done_nxt  = 1'b1;
          else            w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        BUSY      = 1'b1;
        DIN_READY = !r_tvalid || AXIS_M_TREADY;
        if (DIN_VALID && (!r_tvalid || AXIS_M_TREADY) && w_last_beat)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        BUSY = 1'b1;
        if (w_out_fire) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op      <= 2'b00;
      r_dest    <= '0;
      r_count   <= 8'd0;
      r_rf_addr <= 9'd0;
      r_l       <= '0;
      r_r       <= 8'd0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tlast   <= 1'b0;
      r_tuser   <= '0;
      r_tdest   <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_op      <= CMD_OP;
        r_dest    <= CMD_DEST;
        r_count   <= CMD_COUNT;
        r_rf_addr <= CMD_RF_ADDR;
        r_l       <= '0;
        r_r       <= 8'd0;
      end
      // Single output stage: a new beat only loads when the slot is free or draining now
      if (w_din_fire) begin
        r_tvalid <= 1'b1;
        r_tdata  <= DIN_DATA;
        r_tlast  <= 1'b1;
        r_tuser  <= {w_lane_sel, r_op, w_rf};
        r_tdest  <= r_dest + DESTW'(r_r);
        if (r_op == OP_WEIGHT) begin
          if (w_lane_last) begin
            r_l <= '0;
            r_r <= r_r + 8'd1;
          end else begin
            r_l <= r_l + LW'(1);
          end
        end else begin
          r_r <= r_r + 8'd1;
        end
      end else if (w_out_fire) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign AXIS_M_TVALID = r_tvalid;
  assign AXIS_M_TDATA  = r_tdata;
  assign AXIS_M_TLAST  = r_tlast;
  assign AXIS_M_TID    = '0;
  assign AXIS_M_TUSER  = r_tuser;
  assign AXIS_M_TDEST  = r_tdest;
  assign DONE          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mvm_axis_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mvm_axis_loader
// Purpose  : Randomised self-checking bench for mvm_axis_loader against a
//            flit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvm_axis_loader;
  localparam int DATAW = 512;
  localparam int DESTW = 12;
  localparam int IDW   = 12;
  localparam int USERW = 75;
  localparam int LANES = 64;

  logic             CLK, RST_N;
  logic             CMD_VALID, CMD_READY;
  logic [1:0]       CMD_OP;
  logic [DESTW-1:0] CMD_DEST;
  logic [7:0]       CMD_COUNT;
  logic [8:0]       CMD_RF_ADDR;
  logic             DIN_VALID, DIN_READY;
  logic [DATAW-1:0] DIN_DATA;
  logic             AXIS_M_TVALID, AXIS_M_TREADY, AXIS_M_TLAST;
  logic [DATAW-1:0] AXIS_M_TDATA;
  logic [IDW-1:0]   AXIS_M_TID;
  logic [USERW-1:0] AXIS_M_TUSER;
  logic [DESTW-1:0] AXIS_M_TDEST;
  logic             BUSY, DONE;

  mvm_axis_loader #(.DATAW(DATAW), .DESTW(DESTW), .IDW(IDW), .USERW(USERW), .LANES(LANES)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_DEST(CMD_DEST),
    .CMD_COUNT(CMD_COUNT), .CMD_RF_ADDR(CMD_RF_ADDR),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN_DATA(DIN_DATA),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY), .AXIS_M_TDATA(AXIS_M_TDATA),
    .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TUSER(AXIS_M_TUSER),
    .AXIS_M_TDEST(AXIS_M_TDEST), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct packed {
    logic             last;
    logic [IDW-1:0]   id;
    logic [DESTW-1:0] dest;
    logic [USERW-1:0] user;
    logic [DATAW-1:0] data;
  } flit_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int din_pct = 100;
  int rdy_pct = 100;
  int stall_err = 0;

  flit_t            exp_q[$];
  flit_t            obs_q[$];
  int               obs_edge[$];
  int               cmd_edges[$];
  int               done_cycs[$];
  logic [DATAW-1:0] din_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    AXIS_M_TREADY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      AXIS_M_TREADY = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    DIN_VALID = 1'b0;
    DIN_DATA  = '0;
    forever begin
      @(posedge CLK); #1;
      if (din_q.size() > 0 && $urandom_range(99) < din_pct) begin
        DIN_VALID = 1'b1;
        DIN_DATA  = din_q[0];
      end else begin
        DIN_VALID = 1'b0;
        DIN_DATA  = '0;
      end
    end
  end

  // Passive observer: inputs only change just after posedge, so negedge values
  // predict exactly which handshakes complete on the following edge.
  initial begin
    flit_t cur, prev_f;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev_f     = '0;
    forever begin
      @(negedge CLK);
      cur = {AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST, AXIS_M_TUSER, AXIS_M_TDATA};
      if (RST_N) begin
        if (prev_stall && (!AXIS_M_TVALID || cur !== prev_f)) stall_err++;
        if (CMD_VALID && CMD_READY) cmd_edges.push_back(cyc + 1);
        if (DIN_VALID && DIN_READY) void'(din_q.pop_front());
        if (AXIS_M_TVALID && AXIS_M_TREADY) begin
          obs_q.push_back(cur);
          obs_edge.push_back(cyc + 1);
        end
        if (DONE) done_cycs.push_back(cyc);
        prev_stall = AXIS_M_TVALID && !AXIS_M_TREADY;
        prev_f     = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  function automatic logic [DATAW-1:0] rand_data();
    logic [DATAW-1:0] d;
    for (int k = 0; k < DATAW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: flit i of a job derives directly from the job's arithmetic.
  function automatic flit_t model_flit(input logic [1:0] op, input logic [DESTW-1:0] dest,
                                       input logic [8:0] rf, input int i, input logic [DATAW-1:0] d);
    flit_t f;
    int lane, rt;
    lane = (op == 2'b11) ? (i % LANES) : 0;
    rt   = (op == 2'b11) ? (i / LANES) : i;
    f = '0;
    f.data = d;
    f.dest = dest + DESTW'(rt);
    f.last = 1'b1;
    f.user[10:9] = op;
    if (op == 2'b11) begin
      f.user[8:0] = rf;
      f.user[11 + lane] = 1'b1;
    end
    return f;
  endfunction

  task automatic load_job(input logic [1:0] op, input logic [DESTW-1:0] dest, input logic [7:0] count,
                          input logic [8:0] rf, input bit fixed);
    int nb;
    logic [DATAW-1:0] d;
    nb = (op == 2'b01) ? 0 : ((op == 2'b11) ? int'(count) * LANES : int'(count));
    for (int i = 0; i < nb; i++) begin
      d = fixed ? DATAW'(32'h8060200A) : rand_data();
      din_q.push_back(d);
      exp_q.push_back(model_flit(op, dest, rf, i, d));
    end
  endtask

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); obs_edge.delete();
    cmd_edges.delete(); done_cycs.delete(); din_q.delete();
    stall_err = 0;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [DESTW-1:0] dest, input logic [7:0] count,
                           input logic [8:0] rf, output bit to);
    int n;
    to = 1'b0;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DEST = dest; CMD_COUNT = count; CMD_RF_ADDR = rf;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CMD_READY && n < 1000);
    if (!CMD_READY) to = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int ndone, inout bit to);
    int n;
    n = 0;
    while (done_cycs.size() < ndone && n < 20000) begin tick(); n++; end
    if (done_cycs.size() < ndone) to = 1'b1;
    repeat (4) tick();
  endtask

  task automatic run_job(input logic [1:0] op, input logic [DESTW-1:0] dest, input logic [7:0] count,
                         input logic [8:0] rf, input int dpct, input int rpct, input bit fixed, output bit to);
    clear_obs();
    load_job(op, dest, count, rf, fixed);
    din_pct = dpct;
    rdy_pct = rpct;
    issue_cmd(op, dest, count, rf, to);
    wait_done(1, to);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_DEST = '0; CMD_COUNT = 8'd0; CMD_RF_ADDR = 9'd0;
    repeat (3) tick();
    checks++;
    if ({AXIS_M_TVALID, AXIS_M_TLAST, DONE, BUSY, DIN_READY, CMD_READY} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 000001", {AXIS_M_TVALID, AXIS_M_TLAST, DONE, BUSY, DIN_READY, CMD_READY});
    end
    checks++;
    if ({AXIS_M_TDATA, AXIS_M_TUSER, AXIS_M_TDEST, AXIS_M_TID} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got user %h dest %h id %h, exp all zero", AXIS_M_TUSER, AXIS_M_TDEST, AXIS_M_TID);
    end
    RST_N = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_weight();
    bit to;
    run_job(2'b11, 12'h001, 8'd2, 9'h001, 100, 100, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL weight_timeout: got timeout exp done"); end
    checks++;
    if (obs_q.size() != 128) begin errors++; $display("FAIL weight_count: got %0d exp 128", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL weight_flit%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cycs.size() != 1) begin errors++; $display("FAIL weight_done_count: got %0d exp 1", done_cycs.size()); end
    if (obs_edge.size() == 128 && done_cycs.size() >= 1 && cmd_edges.size() >= 1) begin
      checks++;
      if (done_cycs[0] != obs_edge[127]) begin
        errors++; $display("FAIL weight_done_time: got %0d exp %0d", done_cycs[0], obs_edge[127]);
      end
      checks++;
      if (obs_edge[0] != cmd_edges[0] + 2) begin
        errors++; $display("FAIL weight_latency: got %0d exp %0d", obs_edge[0], cmd_edges[0] + 2);
      end
      checks++;
      if (obs_edge[127] != obs_edge[0] + 127) begin
        errors++; $display("FAIL weight_throughput: got %0d exp %0d", obs_edge[127], obs_edge[0] + 127);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    run_job(2'b11, 12'h001, 8'd2, 9'h001, 60, 50, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout exp done"); end
    checks++;
    if (obs_q.size() != 128) begin errors++; $display("FAIL bp_count: got %0d exp 128", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_flit%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls exp 0", stall_err); end
    checks++;
    if (done_cycs.size() != 1) begin errors++; $display("FAIL bp_done_count: got %0d exp 1", done_cycs.size()); end
  endtask

  task automatic test_vector_instr();
    bit to;
    run_job(2'b10, 12'h002, 8'd1, 9'h1FF, 100, 100, 1'b0, to);
    checks++;
    if (to || obs_q.size() != 1) begin
      errors++; $display("FAIL vec_count: got %0d flits (timeout %0d) exp 1", obs_q.size(), to);
    end else if (obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL vec_flit: got %h exp %h", obs_q[0], exp_q[0]);
    end
    run_job(2'b00, 12'h005, 8'd1, 9'h055, 70, 70, 1'b1, to);
    checks++;
    if (to || obs_q.size() != 1) begin
      errors++; $display("FAIL instr_count: got %0d flits (timeout %0d) exp 1", obs_q.size(), to);
    end else if (obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL instr_flit: got %h exp %h", obs_q[0], exp_q[0]);
    end
  endtask

  task automatic test_wrap_degenerate();
    bit to;
    run_job(2'b10, 12'hFFF, 8'd2, 9'h000, 80, 60, 1'b0, to);
    checks++;
    if (to || obs_q.size() != 2) begin
      errors++; $display("FAIL wrap_count: got %0d flits (timeout %0d) exp 2", obs_q.size(), to);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL wrap_flit%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    run_job(2'b10, 12'h010, 8'd0, 9'h000, 100, 100, 1'b0, to);
    checks++;
    if (to || obs_q.size() != 0 || done_cycs.size() != 1 || cmd_edges.size() != 1) begin
      errors++; $display("FAIL count0: got %0d flits %0d dones (timeout %0d) exp 0 flits 1 done",
                         obs_q.size(), done_cycs.size(), to);
    end else if (done_cycs[0] != cmd_edges[0]) begin
      errors++; $display("FAIL count0_time: got %0d exp %0d", done_cycs[0], cmd_edges[0]);
    end
    run_job(2'b01, 12'h010, 8'd3, 9'h000, 100, 100, 1'b0, to);
    checks++;
    if (to || obs_q.size() != 0 || done_cycs.size() != 1 || cmd_edges.size() != 1) begin
      errors++; $display("FAIL op01: got %0d flits %0d dones (timeout %0d) exp 0 flits 1 done",
                         obs_q.size(), done_cycs.size(), to);
    end else if (done_cycs[0] != cmd_edges[0]) begin
      errors++; $display("FAIL op01_time: got %0d exp %0d", done_cycs[0], cmd_edges[0]);
    end
  endtask

  task automatic test_reset_midjob();
    bit to;
    int n;
    clear_obs();
    load_job(2'b11, 12'h001, 8'd2, 9'h001, 1'b0);
    din_pct = 100; rdy_pct = 100;
    issue_cmd(2'b11, 12'h001, 8'd2, 9'h001, to);
    n = 0;
    while (obs_q.size() < 30 && n < 2000) begin tick(); n++; end
    checks++;
    if (obs_q.size() < 30) begin errors++; $display("FAIL rst_mid_progress: got %0d flits exp 30", obs_q.size()); end
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({AXIS_M_TVALID, CMD_READY, BUSY, DIN_READY} !== 4'b0100) begin
      errors++; $display("FAIL rst_mid_flush: got %b exp 0100", {AXIS_M_TVALID, CMD_READY, BUSY, DIN_READY});
    end
    din_q.delete();
    @(posedge CLK); #2;
    RST_N = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cycs.size() != 0) begin errors++; $display("FAIL rst_mid_done: got %0d dones exp 0", done_cycs.size()); end
    run_job(2'b11, 12'h010, 8'd1, 9'h0AB, 90, 90, 1'b0, to);
    checks++;
    if (to || obs_q.size() != 64) begin
      errors++; $display("FAIL rst_after_count: got %0d flits (timeout %0d) exp 64", obs_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_after_flit%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    clear_obs();
    load_job(2'b10, 12'h020, 8'd3, 9'h000, 1'b0);
    load_job(2'b00, 12'h030, 8'd2, 9'h000, 1'b0);
    din_pct = 100; rdy_pct = 100;
    issue_cmd(2'b10, 12'h020, 8'd3, 9'h000, to1);
    issue_cmd(2'b00, 12'h030, 8'd2, 9'h000, to2);
    wait_done(2, to2);
    checks++;
    if (to1 || to2 || obs_q.size() != 5 || done_cycs.size() != 2 || cmd_edges.size() != 2) begin
      errors++; $display("FAIL b2b_counts: got %0d flits %0d dones %0d cmds exp 5 2 2",
                         obs_q.size(), done_cycs.size(), cmd_edges.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_flit%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (cmd_edges[1] != done_cycs[0] + 1) begin
        errors++; $display("FAIL b2b_accept: got %0d exp %0d", cmd_edges[1], done_cycs[0] + 1);
      end
      checks++;
      if (obs_edge[3] != cmd_edges[1] + 2) begin
        errors++; $display("FAIL b2b_first_flit: got %0d exp %0d", obs_edge[3], cmd_edges[1] + 2);
      end
      checks++;
      if (done_cycs[1] != obs_edge[4]) begin
        errors++; $display("FAIL b2b_done2: got %0d exp %0d", done_cycs[1], obs_edge[4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_weight();
    test_backpressure();
    test_vector_instr();
    test_wrap_degenerate();
    test_reset_midjob();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
